mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single line-wide backing memory port between the instruction-side and data-side
//  caches. Each requester exposes the cache miss/writeback interface (req, we, addr, 128-bit line).
//  Sits between both caches and main memory, directly below the pipelined core.
//  Arbitration: D-side wins by default; a starvation guard forces an I-side grant after a bound.
// PARAMETERS
//  ADDR_WIDTH  32   byte address width of line requests
//  LINE_WIDTH  128  cache line width in bits
//  MAX_CONSEC  4    max consecutive D grants while I is waiting; >=1
// PORTS
//  clk        in   1           system clock, all state on rising edge
//  rst        in   1           asynchronous, active-low reset
//  i_req      in   1           I-side request, held until i_ready
//  i_we       in   1           I-side write (line writeback); 0 = line fill
//  i_addr     in   ADDR_WIDTH  I-side line address
//  i_wdata    in   LINE_WIDTH  I-side write line
//  i_rdata    out  LINE_WIDTH  I-side read line, valid with i_ready
//  i_ready    out  1           I-side completion pulse, 1 cycle
//  d_req, d_we, d_addr, d_wdata, d_rdata, d_ready   same as I-side, for the data cache
//  mem_req    out  1           request to memory
//  mem_we     out  1           memory write enable
//  mem_addr   out  ADDR_WIDTH  memory line address
//  mem_wdata  out  LINE_WIDTH  memory write line
//  mem_rdata  in   LINE_WIDTH  memory read line, valid with mem_ready
//  mem_ready  in   1           memory completion pulse
//  grant      out  2           one-hot current owner: [1]=D, [0]=I; 00 when idle
// BEHAVIOUR
//  - FSM states: IDLE, GNT_I, GNT_D, TURN.
//    Reset: state IDLE, starve_cnt 0.
//    All outputs 0, including grant, mem_* and *_ready.
//  - IDLE: arbitrate using the req inputs sampled at the edge.
//    - d_req & (!i_req | starve_cnt<MAX_CONSEC) -> GNT_D.
//    - i_req and not GNT_D -> GNT_I.
//    - neither -> stay in IDLE.
//  - Starvation guard (updated only on IDLE->GNT_D transitions):
//    - IDLE->GNT_D with i_req=1: starve_cnt++, saturating at MAX_CONSEC.
//    - IDLE->GNT_D with i_req=0: starve_cnt cleared.
//    - IDLE->GNT_I: starve_cnt cleared.
//  - GNT_x:
//    - mem_req=1.
//    - mem_we/mem_addr/mem_wdata are muxed combinationally from owner x's inputs.
//    - x_ready=mem_ready, gated by grant; x_rdata=mem_rdata.
//    - The non-owner's ready is always 0.
//    - Stay in GNT_x until mem_ready=1, then -> TURN.
//  - TURN: one mandatory dead cycle with mem_req=0 and grant=00, then -> IDLE.
//    This gives the requester time to drop req after its ready pulse.
//  - Latency: req high at edge n -> mem_req at n+1.
//    For memory latency L cycles (mem_ready L cycles after mem_req rises): ready at n+L+1.
//    Next grant is possible at n+L+3.
//  - Simultaneous i_req & d_req in IDLE: D wins unless starve_cnt==MAX_CONSEC.
//  - Requester drops req while granted (protocol error):
//    - grant is held and mem_* keep the current input values until mem_ready.
//    - The simulation assertion fires.
//  - A req seen in TURN is ignored until IDLE; no request is lost because req is level-held.
//  - Reset mid-transaction: the in-flight access is abandoned and all outputs return to 0
//    immediately (async). The memory model must accept mem_req dropping without mem_ready.
//  - mem_ready in IDLE/TURN: ignored; no ready is forwarded.
// STRUCTURE
//  - mem_arb_pkg holds:
//    - typedef enum logic [1:0] arb_state_t {IDLE, GNT_I, GNT_D, TURN}.
//    - localparam LINE_WIDTH_DEF=128.
//    - grant bit indices GNT_I_BIT=0 and GNT_D_BIT=1.
//  - Single module with no sub-modules.
//    - The starvation counter is $clog2(MAX_CONSEC+1) bits, kept inline.
//    - The payload mux is a plain always_comb.
// TESTING
//  - Reset: hold rst=0 with d_req=1 -> grant=00, mem_req=0.
//    Release -> GNT_D next edge.
//  - Single I fill: i_req=1, i_addr=0x0000_1000, memory L=3 -> mem_addr=0x1000.
//    i_ready pulses at n+4 with i_rdata=mem_rdata; d_ready stays 0.
//  - Contention: i_req=d_req=1 continuously, MAX_CONSEC=4 -> grant sequence D,D,D,D,I,D,...
//    Check starve_cnt saturation and the reset of starve_cnt on the I grant.
//  - D writeback: d_we=1, d_wdata=128'hDEAD..BEEF -> mem_we=1, mem_wdata matches for the whole grant.
//    The TURN cycle shows mem_req=0.
//  - Async reset mid-GNT_D (rst low between edges) -> outputs 0 in the same cycle.
//    After release with only i_req=1 -> GNT_I.
//  - Stray mem_ready=1 in IDLE -> no i_ready/d_ready pulse, state unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory-port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, TURN} arb_state_t;

   localparam int LINE_WIDTH_DEF = 128;
   localparam int GNT_I_BIT      = 0;
   localparam int GNT_D_BIT      = 1;
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single line-wide memory port between I-side and D-side caches.
// D-side wins by default; a starvation counter forces an I grant after MAX_CONSEC D wins.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = LINE_WIDTH_DEF,
   parameter int MAX_CONSEC = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [LINE_WIDTH-1:0] i_wdata,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_ready,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_ready,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic [1:0]            grant
);

   localparam int               CNT_W   = $clog2(MAX_CONSEC + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CONSEC);

   arb_state_t       state, nextState;
   logic [CNT_W-1:0] starveCnt, starveCntNext;
   logic             dWins;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         starveCnt <= '0;
      end else begin
         state     <= nextState;
         starveCnt <= starveCntNext;
      end
   end

   // D loses a simultaneous request only once the I side has been passed over MAX_CONSEC times.
   assign dWins = d_req && (!i_req || (starveCnt < MAX_CNT));

   always_comb begin
      nextState     = state;
      starveCntNext = starveCnt;
      case (state)
         IDLE: begin
            if (dWins) begin
               nextState = GNT_D;
               if (!i_req)
                  starveCntNext = '0;
               else if (starveCnt != MAX_CNT)
                  starveCntNext = starveCnt + CNT_W'(1);
            end else if (i_req) begin
               nextState     = GNT_I;
               starveCntNext = '0;
            end
         end
         GNT_I, GNT_D: begin
            if (mem_ready)
               nextState = TURN;
         end
         TURN:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      grant     = 2'b00;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_ready   = 1'b0;
      i_rdata   = '0;
      d_ready   = 1'b0;
      d_rdata   = '0;
      case (state)
         GNT_I: begin
            grant[GNT_I_BIT] = 1'b1;
            mem_req          = 1'b1;
            mem_we           = i_we;
            mem_addr         = i_addr;
            mem_wdata        = i_wdata;
            i_ready          = mem_ready;
            i_rdata          = mem_rdata;
         end
         GNT_D: begin
            grant[GNT_D_BIT] = 1'b1;
            mem_req          = 1'b1;
            mem_we           = d_we;
            mem_addr         = d_addr;
            mem_wdata        = d_wdata;
            d_ready          = mem_ready;
            d_rdata          = mem_rdata;
         end
         default: ;
      endcase
   end

   // A granted requester must keep req high until its ready pulse.
   assert property (@(posedge clk) disable iff (!rst)
                    (state == GNT_I && !mem_ready) |-> i_req);
   assert property (@(posedge clk) disable iff (!rst)
                    (state == GNT_D && !mem_ready) |-> d_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
   localparam int AW   = 32;
   localparam int LW   = 128;
   localparam int MAXC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_req = 1'b0, i_we = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [LW-1:0] i_wdata = '0;
   logic [LW-1:0] i_rdata;
   logic          i_ready;
   logic          d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [LW-1:0] d_wdata = '0;
   logic [LW-1:0] d_rdata;
   logic          d_ready;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_ready;
   logic [1:0]    grant;

   int vectors     = 0;
   int miscompares = 0;
   int consec      = 0;

   // Memory model: mem_ready pulses memLat cycles after mem_req rises, tolerates mem_req dropping.
   int   memLat     = 2;
   int   latCnt     = 0;
   logic memReadyR  = 1'b0;
   logic strayReady = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_req && !memReadyR) begin
         if (latCnt >= memLat - 1) begin
            memReadyR <= 1'b1;
            latCnt    <= 0;
            mem_rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
         end else begin
            memReadyR <= 1'b0;
            latCnt    <= latCnt + 1;
         end
      end else begin
         memReadyR <= 1'b0;
         latCnt    <= 0;
      end
   end

   assign mem_ready = memReadyR | strayReady;

   mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_CONSEC(MAXC)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant)
   );

   // Arbitration rule: D is served unless I has been passed over MAXC times in a row.
   task automatic modelPick(input bit ir, input bit dr, output bit pickD);
      pickD = dr && (!ir || consec < MAXC);
      if (pickD) consec = ir ? ((consec < MAXC) ? consec + 1 : MAXC) : 0;
      else       consec = 0;
   endtask

   task automatic doReset();
      i_req = 1'b0;
      d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      consec = 0;
   endtask

   // Let outstanding requests complete (dropping only ungranted or finished ones).
   task automatic drain(output bit ok);
      int quiet = 0;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (i_ready || !grant[0]) i_req = 1'b0;
         if (d_ready || !grant[1]) d_req = 1'b0;
         if (!i_req && !d_req && grant == 2'b00) quiet++;
         else quiet = 0;
         if (quiet >= 3) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      memLat  = 2;
      d_we    = 1'b0;
      d_addr  = $urandom();
      d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      d_req   = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b want 00", grant); end
      vectors++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0) begin
         miscompares++; $display("FAIL reset_mem: got req=%b we=%b addr=%h want 0", mem_req, mem_we, mem_addr);
      end
      vectors++;
      if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_ready: got i=%b d=%b want 0", i_ready, d_ready);
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (grant !== 2'b10 || mem_req !== 1'b1 || mem_addr !== d_addr) begin
         miscompares++;
         $display("FAIL reset_release: got grant=%b req=%b addr=%h want 10/1/%h", grant, mem_req, mem_addr, d_addr);
      end
      drain(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL reset_drain: got timeout want idle"); end
   endtask

   task automatic test_single_fill();
      bit ok;
      memLat  = 3;
      d_req   = 1'b0;
      i_we    = 1'b0;
      i_addr  = 32'h0000_1000;
      i_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      i_req   = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         @(negedge clk);
         vectors++;
         if (d_ready !== 1'b0) begin miscompares++; $display("FAIL fill_d_ready t=%0d: got %b want 0", t, d_ready); end
         vectors++;
         if (i_ready !== (t == 4)) begin
            miscompares++; $display("FAIL fill_i_ready t=%0d: got %b want %b", t, i_ready, (t == 4));
         end
         if (t == 4) begin
            vectors++;
            if (i_rdata !== mem_rdata) begin
               miscompares++; $display("FAIL fill_rdata: got %h want %h", i_rdata, mem_rdata);
            end
         end
         if (t <= 4) begin
            vectors++;
            if (grant !== 2'b01 || mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_we !== 1'b0) begin
               miscompares++;
               $display("FAIL fill_grant t=%0d: got grant=%b req=%b addr=%h we=%b want 01/1/00001000/0",
                        t, grant, mem_req, mem_addr, mem_we);
            end
         end
         if (t == 5) begin
            vectors++;
            if (grant !== 2'b00 || mem_req !== 1'b0) begin
               miscompares++; $display("FAIL fill_turn: got grant=%b req=%b want 00/0", grant, mem_req);
            end
         end
         if (i_ready) i_req = 1'b0;
      end
      drain(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL fill_drain: got timeout want idle"); end
   endtask

   task automatic test_contention();
      bit       ok, pickD;
      int       seen = 0;
      logic [1:0] prevGrant = 2'b00;
      logic [1:0] expGrant;
      doReset();
      memLat = $urandom_range(1, 3);
      i_we = 1'b0; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 300 && seen < 10; k++) begin
         @(negedge clk);
         if (prevGrant == 2'b00 && grant != 2'b00) begin
            modelPick(1'b1, 1'b1, pickD);
            expGrant = pickD ? 2'b10 : 2'b01;
            vectors++;
            if (grant !== expGrant) begin
               miscompares++; $display("FAIL contention_grant#%0d: got %b want %b", seen, grant, expGrant);
            end
            seen++;
         end
         prevGrant = grant;
      end
      vectors++;
      if (seen != 10) begin miscompares++; $display("FAIL contention_count: got %0d want 10", seen); end
      drain(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL contention_drain: got timeout want idle"); end
   endtask

   task automatic test_d_writeback();
      bit         ok;
      bit         seenReady = 1'b0;
      bit         turnSeen  = 1'b0;
      int         gntCycles = 0;
      logic [LW-1:0] wb;
      wb      = 128'hDEADBEEF_01234567_89ABCDEF_0000BEEF;
      memLat  = 4;
      d_we    = 1'b1;
      d_wdata = wb;
      d_addr  = $urandom();
      d_req   = 1'b1;
      for (int t = 0; t < 30 && !turnSeen; t++) begin
         @(negedge clk);
         if (seenReady) begin
            vectors++;
            if (mem_req !== 1'b0 || grant !== 2'b00) begin
               miscompares++; $display("FAIL wb_turn: got req=%b grant=%b want 0/00", mem_req, grant);
            end
            turnSeen = 1'b1;
         end else if (grant == 2'b10) begin
            gntCycles++;
            vectors++;
            if (mem_we !== 1'b1 || mem_wdata !== wb || mem_req !== 1'b1) begin
               miscompares++; $display("FAIL wb_payload: got we=%b wdata=%h want 1/%h", mem_we, mem_wdata, wb);
            end
         end
         if (d_ready) begin
            seenReady = 1'b1;
            d_req     = 1'b0;
         end
      end
      vectors++;
      if (!turnSeen || gntCycles != memLat + 1) begin
         miscompares++; $display("FAIL wb_length: got %0d grant cycles want %0d", gntCycles, memLat + 1);
      end
      d_we = 1'b0;
      drain(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL wb_drain: got timeout want idle"); end
   endtask

   task automatic test_async_reset();
      bit ok;
      memLat = 5;
      d_we   = 1'b0;
      d_req  = 1'b1;
      @(negedge clk);
      vectors++;
      if (grant !== 2'b10) begin miscompares++; $display("FAIL areset_pre: got %b want 10", grant); end
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if (grant !== 2'b00 || mem_req !== 1'b0 || d_ready !== 1'b0 || mem_addr !== '0) begin
         miscompares++;
         $display("FAIL areset_outputs: got grant=%b req=%b dready=%b addr=%h want 0", grant, mem_req, d_ready, mem_addr);
      end
      d_req  = 1'b0;
      i_we   = 1'b0;
      i_addr = $urandom();
      i_req  = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      consec = 0;
      @(negedge clk);
      vectors++;
      if (grant !== 2'b01 || mem_addr !== i_addr) begin
         miscompares++; $display("FAIL areset_regrant: got grant=%b addr=%h want 01/%h", grant, mem_addr, i_addr);
      end
      drain(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL areset_drain: got timeout want idle"); end
   endtask

   task automatic test_stray_ready();
      bit ok;
      strayReady = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         vectors++;
         if (i_ready !== 1'b0 || d_ready !== 1'b0 || grant !== 2'b00) begin
            miscompares++; $display("FAIL stray_ready: got i=%b d=%b grant=%b want 0/0/00", i_ready, d_ready, grant);
         end
      end
      strayReady = 1'b0;
      memLat = 2;
      d_req  = 1'b1;
      @(negedge clk);
      vectors++;
      if (grant !== 2'b10) begin miscompares++; $display("FAIL stray_after: got %b want 10", grant); end
      drain(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL stray_drain: got timeout want idle"); end
   endtask

   // Random traffic: phase 0 = idle, 1 = owned, 2 = dead cycle after completion.
   task automatic test_random();
      bit   ok, pickD, owner, doneI, doneD;
      int   phase = 0;
      int   oldPhase;
      logic [1:0] expGrant;
      doReset();
      memLat = $urandom_range(1, 4);
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (phase == 1) begin
            expGrant = owner ? 2'b10 : 2'b01;
            vectors++;
            if (grant !== expGrant || mem_req !== 1'b1) begin
               miscompares++; $display("FAIL rand_grant c=%0d: got %b/%b want %b/1", cyc, grant, mem_req, expGrant);
            end
            vectors++;
            if (mem_addr !== (owner ? d_addr : i_addr) || mem_we !== (owner ? d_we : i_we) ||
                mem_wdata !== (owner ? d_wdata : i_wdata)) begin
               miscompares++; $display("FAIL rand_payload c=%0d: got addr=%h we=%b", cyc, mem_addr, mem_we);
            end
            vectors++;
            if ((owner ? d_ready : i_ready) !== mem_ready || (owner ? i_ready : d_ready) !== 1'b0) begin
               miscompares++; $display("FAIL rand_ready c=%0d: got i=%b d=%b mem=%b", cyc, i_ready, d_ready, mem_ready);
            end
            if (mem_ready) begin
               vectors++;
               if ((owner ? d_rdata : i_rdata) !== mem_rdata) begin
                  miscompares++; $display("FAIL rand_rdata c=%0d: got i=%h d=%h want %h", cyc, i_rdata, d_rdata, mem_rdata);
               end
            end
         end else begin
            vectors++;
            if (grant !== 2'b00 || mem_req !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL rand_idle c=%0d: got grant=%b req=%b i=%b d=%b want 0", cyc, grant, mem_req, i_ready, d_ready);
            end
         end
         oldPhase = phase;
         doneI = (oldPhase == 1) && !owner && mem_ready;
         doneD = (oldPhase == 1) && owner && mem_ready;
         if (doneI) i_req = 1'b0;
         else if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req   = 1'b1;
            i_we    = 1'($urandom_range(0, 1));
            i_addr  = $urandom();
            i_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         if (doneD) d_req = 1'b0;
         else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom();
            d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         if (oldPhase == 0 && (i_req || d_req)) begin
            modelPick(i_req, d_req, pickD);
            owner = pickD;
            phase = 1;
         end else if (oldPhase == 1 && mem_ready) begin
            phase = 2;
         end else if (oldPhase == 2) begin
            phase  = 0;
            memLat = $urandom_range(1, 4);
         end
      end
      drain(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rand_drain: got timeout want idle"); end
   endtask

   initial begin
      test_reset();
      test_single_fill();
      test_contention();
      test_d_writeback();
      test_async_reset();
      test_stray_ready();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
